ccr_ctx: RTL and testbench

CCR_CTX -- requirements
Module: ccr_ctx

---
 rtl/ccr_pkg.sv | 22 ++
 rtl/ccr_ctx_if.sv | 28 ++
 rtl/ccr_lifo.sv | 83 ++++++++
 rtl/ccr_ctx.sv | 85 ++++++++
 tb/tb_ccr_ctx.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/ccr_pkg.sv
// ccr_pkg: shared constants and types for the CCR context block.
// Flag bit positions, default sizing and the stack operation encoding.
package ccr_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int NFLAGS_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  // One stack operation per cycle; the top level resolves save/restore
  // combinations (including dropped requests) into exactly one of these.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } lifo_op_e;

endpackage

// File: rtl/ccr_ctx_if.sv
// ccr_ctx_if: flag update / context save-restore bus of ccr_ctx.
// master drives requests, slave (the CCR block) returns registered state.
interface ccr_ctx_if #(
  parameter int NFLAGS = ccr_pkg::NFLAGS_DEF,
  parameter int CW     = $clog2(ccr_pkg::DEPTH_DEF + 1)
);
  logic [NFLAGS-1:0] flag_in;
  logic [NFLAGS-1:0] flag_mask;
  logic              flag_we;
  logic              save;
  logic              restore;
  logic              err_clr;
  logic [NFLAGS-1:0] ccr_out;
  logic [CW-1:0]     depth;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output flag_in, flag_mask, flag_we, save, restore, err_clr,
    input  ccr_out, depth, full, empty, err
  );

  modport slave (
    input  flag_in, flag_mask, flag_we, save, restore, err_clr,
    output ccr_out, depth, full, empty, err
  );
endinterface

// File: rtl/ccr_lifo.sv
// ccr_lifo: context stack storage and depth pointer.
// Storage is not reset; only the pointer is, so reset discards all entries.
// Entries at or above the pointer are never read out (top reads 0 when empty).
module ccr_lifo
  import ccr_pkg::*;
#(
  parameter int W     = NFLAGS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  lifo_op_e      i_op,
  input  logic [W-1:0]  i_din,
  output logic [W-1:0]  o_top,
  output logic [CW-1:0] o_depth,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_empty;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_top_idx;
  logic [CW-1:0] w_wr_idx;
  logic          w_wr_en;

  assign w_top_idx = r_cnt - CW'(1);

  // Next pointer and write slot: push writes above top, swap overwrites top.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_wr_idx  = r_cnt;
    w_wr_en   = 1'b0;
    case (i_op)
      OP_PUSH: begin
        w_cnt_nxt = r_cnt + CW'(1);
        w_wr_en   = 1'b1;
      end
      OP_POP:  w_cnt_nxt = r_cnt - CW'(1);
      OP_SWAP: begin
        w_wr_idx = w_top_idx;
        w_wr_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Storage write, no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_en && w_wr_idx == CW'(i)) r_mem[i] <= i_din;
    end
  end

  // Top-of-stack read; an empty stack wraps the index out of range and reads 0.
  always_comb begin
    o_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_top_idx == CW'(i)) o_top = r_mem[i];
    end
  end

  // Pointer with registered full/empty flags derived from the next count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_depth = r_cnt;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/ccr_ctx.sv
// ccr_ctx: condition-code register with a nested save/restore context stack.
// Optional macro CCR_CTX_ERR_EN enables the sticky stack-misuse flag; without
// it err is tied to 0 and err_clr is ignored (misuse is still dropped).
module ccr_ctx
  import ccr_pkg::*;
#(
  parameter int NFLAGS = NFLAGS_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  ccr_ctx_if.slave io
);

  logic [NFLAGS-1:0] r_ccr;
  logic [NFLAGS-1:0] w_top;
  logic [NFLAGS-1:0] w_ccr_upd;
  logic              w_full;
  logic              w_empty;
  logic              w_misuse;
  lifo_op_e          w_op;

  assign w_ccr_upd = (r_ccr & ~io.flag_mask) | (io.flag_in & io.flag_mask);

  // Resolve save/restore into one stack op; illegal requests become OP_NONE.
  always_comb begin
    w_op = OP_NONE;
    if (io.save && io.restore) begin
      if (!w_empty) w_op = OP_SWAP;
    end else if (io.save) begin
      if (!w_full) w_op = OP_PUSH;
    end else if (io.restore) begin
      if (!w_empty) w_op = OP_POP;
    end
  end

  assign w_misuse = (io.save && !io.restore && w_full) ||
                    (io.restore && !io.save && w_empty);

  // CCR: a successful pop/swap loads the old top and masks out flag_we;
  // every other case (push, dropped ops, idle) takes the masked update.
  always_ff @(posedge clk) begin
    if (!rst)                                 r_ccr <= '0;
    else if (w_op == OP_POP || w_op == OP_SWAP) r_ccr <= w_top;
    else if (io.flag_we)                      r_ccr <= w_ccr_upd;
  end

  ccr_lifo #(
    .W     (NFLAGS),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .i_op    (w_op),
    .i_din   (r_ccr),
    .o_top   (w_top),
    .o_depth (io.depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign io.ccr_out = r_ccr;
  assign io.full    = w_full;
  assign io.empty   = w_empty;

`ifdef CCR_CTX_ERR_EN
  logic r_err;

  // Sticky error: a new misuse wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (!rst)          r_err <= 1'b0;
    else if (w_misuse) r_err <= 1'b1;
    else if (io.err_clr) r_err <= 1'b0;
  end

  assign io.err = r_err;
`else
  logic w_unused;
  assign w_unused = io.err_clr ^ w_misuse;
  assign io.err   = 1'b0;
`endif

endmodule

// File: tb/tb_ccr_ctx.sv
// tb_ccr_ctx: directed + random checks of ccr_ctx against a queue-based model.
module tb_ccr_ctx;
  localparam int NF = 4;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ccr_ctx_if #(.NFLAGS(NF), .CW(CW)) bus ();

  ccr_ctx #(.NFLAGS(NF), .DEPTH(DP), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  // Reference model: CCR value, stack as a queue (back = top), sticky error.
  logic [NF-1:0] m_ccr;
  logic [NF-1:0] m_q[$];
  logic          m_err;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rn, input logic we, input logic [NF-1:0] fi,
                       input logic [NF-1:0] fm, input logic sv, input logic rs,
                       input logic ec);
    logic [NF-1:0] upd;
    logic [NF-1:0] tmp;
    logic          bad;
    upd = (m_ccr & ~fm) | (fi & fm);
    bad = 1'b0;
    if (!rn) begin
      m_ccr = '0;
      m_q.delete();
      m_err = 1'b0;
      return;
    end
    if (sv && rs) begin
      if (m_q.size() > 0) begin
        tmp = m_q[$];
        m_q[m_q.size()-1] = m_ccr;
        m_ccr = tmp;
      end else if (we) m_ccr = upd;
    end else if (rs) begin
      if (m_q.size() > 0) m_ccr = m_q.pop_back();
      else begin
        bad = 1'b1;
        if (we) m_ccr = upd;
      end
    end else if (sv) begin
      if (m_q.size() < DP) m_q.push_back(m_ccr);
      else bad = 1'b1;
      if (we) m_ccr = upd;
    end else if (we) m_ccr = upd;
`ifdef CCR_CTX_ERR_EN
    m_err = bad | (m_err & ~ec);
`else
    m_err = 1'b0;
`endif
  endtask

  task automatic check_all();
    chk("ccr",   32'(bus.ccr_out), 32'(m_ccr));
    chk("depth", 32'(bus.depth),   32'(m_q.size()));
    chk("full",  32'(bus.full),    32'(m_q.size() == DP));
    chk("empty", 32'(bus.empty),   32'(m_q.size() == 0));
    chk("err",   32'(bus.err),     32'(m_err));
  endtask

  // Drive one cycle, advance the model on the same edge, check after the edge.
  task automatic step(input logic rn, input logic we, input logic [NF-1:0] fi,
                      input logic [NF-1:0] fm, input logic sv, input logic rs,
                      input logic ec);
    rst           = rn;
    bus.flag_we   = we;
    bus.flag_in   = fi;
    bus.flag_mask = fm;
    bus.save      = sv;
    bus.restore   = rs;
    bus.err_clr   = ec;
    @(posedge clk);
    model(rn, we, fi, fm, sv, rs, ec);
    #1;
    check_all();
  endtask

  logic exp_err;

  initial begin
`ifdef CCR_CTX_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    m_ccr = '0;
    m_err = 1'b0;
    rst = 1'b0;
    bus.flag_we = 0; bus.flag_in = 0; bus.flag_mask = 0;
    bus.save = 0; bus.restore = 0; bus.err_clr = 0;

    // Reset, with other inputs active to show reset overrides them.
    step(0, 1, 4'hF, 4'hF, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_ccr", 32'(bus.ccr_out), 32'h0);

    // Masked update.
    step(1, 1, 4'b1011, 4'b0011, 0, 0, 0);
    chk("mask_upd", 32'(bus.ccr_out), 32'b0011);

    // Save with coincident update, then restore.
    step(1, 1, 4'b0101, 4'hF, 0, 0, 0);
    step(1, 1, 4'b1111, 4'hF, 1, 0, 0);
    chk("save_ccr", 32'(bus.ccr_out), 32'b1111);
    chk("save_dep", 32'(bus.depth), 32'd1);
    step(1, 1, 4'b0000, 4'hF, 0, 1, 0);
    chk("rest_ccr", 32'(bus.ccr_out), 32'b0101);
    chk("rest_emp", 32'(bus.empty), 32'd1);

    // Five saves into a 4-deep stack, then four restores (LIFO order).
    for (int i = 0; i < 5; i++) step(1, 1, 4'(i + 1), 4'hF, 1, 0, 0);
    chk("ovf_full", 32'(bus.full), 32'd1);
    chk("ovf_dep",  32'(bus.depth), 32'd4);
    chk("ovf_err",  32'(bus.err), 32'(exp_err));
    step(1, 0, 0, 0, 0, 1, 1);
    chk("pop1", 32'(bus.ccr_out), 32'd3);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 0);
    chk("pop4", 32'(bus.ccr_out), 32'b0101);

    // Restore on empty: ccr held, error; clear; clear coincident with error.
    step(1, 1, 4'b1001, 4'hF, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("und_ccr", 32'(bus.ccr_out), 32'b1001);
    chk("und_err", 32'(bus.err), 32'(exp_err));
    step(1, 0, 0, 0, 0, 0, 1);
    chk("clr_err", 32'(bus.err), 32'd0);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1);

    // Swap at depth 1, and save+restore at depth 0 (no-op plus update).
    step(1, 1, 4'b0001, 4'hF, 0, 0, 0);
    step(1, 1, 4'b1000, 4'hF, 1, 0, 0);
    step(1, 1, 4'b0110, 4'hF, 1, 1, 0);
    chk("swap_ccr", 32'(bus.ccr_out), 32'b0001);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("swap_top", 32'(bus.ccr_out), 32'b1000);
    step(1, 1, 4'b0110, 4'hF, 1, 1, 0);
    chk("sr0_ccr", 32'(bus.ccr_out), 32'b0110);

    // Reset mid-nesting discards contexts.
    for (int i = 0; i < 3; i++) step(1, 1, 4'(i + 7), 4'hF, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_dep", 32'(bus.depth), 32'd0);
    step(1, 0, 0, 0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
